// File: rtl/wait_mem.sv
// wait_mem: unified instruction/data memory with a fixed number of wait states.
// A req/ready handshake lets the core stall until the access completes.
// Each write has byte-lane enables.
// Optional macro WAIT_MEM_RANGE_CHECK_EN enables the address range check.
//   When it is defined, a word index >= DEPTH raises err and the write is dropped.
//   When it is not defined, the index wraps modulo DEPTH.
module wait_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     adr,
  input  logic [DATA_W-1:0]     wd,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rd,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [3:0]          cnt, cnt_next;

  // Transaction captured at acceptance; it is held until the next acceptance.
  logic                we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   wd_q;
  logic [BYTES-1:0]    be_q;

  // The access in flight.
  // In IDLE this is the bus itself, so a zero-latency access can respond at once.
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_adr;
  logic [ADDR_W-1:0]   acc_word;
  logic [ADDR_W-1:0]   q_word;
  logic                acc_oor;
  logic                q_oor;

  logic [DATA_W-1:0]   rd_next;
  logic                ready_next;
  logic                busy_next;
  logic                err_next;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign acc_we   = (state == IDLE) ? we  : we_q;
  assign acc_adr  = (state == IDLE) ? adr : adr_q;
  assign acc_word = acc_adr >> OFF_W;
  assign q_word   = adr_q >> OFF_W;

`ifdef WAIT_MEM_RANGE_CHECK_EN
  assign acc_oor = (acc_word >= ADDR_W'(DEPTH));
  assign q_oor   = (q_word >= ADDR_W'(DEPTH));
`else
  // The upper index bits alias onto the array, so they play no part here.
  logic unused_hi;
  assign unused_hi = ^{acc_word[ADDR_W-1:IDX_W], q_word[ADDR_W-1:IDX_W]};
  assign acc_oor   = 1'b0;
  assign q_oor     = 1'b0;
`endif

  // Next state, the wait counter and the values the outputs take on the next edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rd_next    = '0;
    ready_next = 1'b0;
    busy_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LAT == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LAT);
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
    busy_next = (state_next != IDLE);
    if (state_next == RESP) begin
      ready_next = 1'b1;
      err_next   = acc_oor;
      if (!acc_we && !acc_oor) begin
        rd_next = mem[acc_word[IDX_W-1:0]];
      end else begin
        rd_next = '0;
      end
    end else begin
      ready_next = 1'b0;
    end
  end

  // State, counter, captured request and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      we_q  <= 1'b0;
      adr_q <= '0;
      wd_q  <= '0;
      be_q  <= '0;
      rd    <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && req) begin
        we_q  <= we;
        adr_q <= adr;
        wd_q  <= wd;
        be_q  <= be;
      end
      rd    <= rd_next;
      ready <= ready_next;
      busy  <= busy_next;
      err   <= err_next;
    end
  end

  // Commit the enabled byte lanes at the edge that ends RESP.
  // The array itself is never reset.
  always_ff @(posedge clk) begin
    if (state == RESP && we_q && !q_oor) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be_q[i]) begin
          mem[q_word[IDX_W-1:0]][8*i +: 8] <= wd_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wait_mem.sv
// Self-checking bench for wait_mem.
// It drives two instances: one with LAT=2 (sel 0) and one with LAT=0 (sel 1).
// A behavioural memory model produces the expected data.
// Expected responses go into a scoreboard queue and are compared when ready pulses.
module tb_wait_mem;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_drv;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wd;
  logic [3:0]  be;
  int          cur;

  logic        req2, req0;
  logic [31:0] rd2, rd0;
  logic        ready2, ready0, busy2, busy0, err2, err0;
  logic [31:0] o_rd;
  logic        o_ready, o_busy, o_err;

  exp_t        sb[$];
  logic [31:0] mdl [2][64];
  int          n_vec;
  int          n_err;

  assign req2    = req_drv && (cur == 0);
  assign req0    = req_drv && (cur == 1);
  assign o_rd    = (cur == 1) ? rd0 : rd2;
  assign o_ready = (cur == 1) ? ready0 : ready2;
  assign o_busy  = (cur == 1) ? busy0 : busy2;
  assign o_err   = (cur == 1) ? err0 : err2;

  wait_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LAT(2)) u_dut (
    .clk(clk), .reset(reset), .req(req2), .we(we), .adr(adr), .wd(wd), .be(be),
    .rd(rd2), .ready(ready2), .busy(busy2), .err(err2)
  );

  wait_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .adr(adr), .wd(wd), .be(be),
    .rd(rd0), .ready(ready0), .busy(busy0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int sel);
    return (sel == 1) ? 0 : 2;
  endfunction

  // Model the access, then queue the response the DUT must give.
  task automatic push_expect(input int sel, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] b);
    exp_t        e;
    logic [31:0] wi;
    logic        oor;
    logic [5:0]  ix;
    wi = a >> 2;
`ifdef WAIT_MEM_RANGE_CHECK_EN
    oor = (wi >= 32'd64);
`else
    oor = 1'b0;
`endif
    ix = wi[5:0];
    e.err = oor;
    e.rd  = (!w && !oor) ? mdl[sel][ix] : 32'h0;
    if (w && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) mdl[sel][ix][8*i +: 8] = d[8*i +: 8];
      end
    end
    sb.push_back(e);
  endtask

  // Check the outputs of a cycle in which ready must be low.
  task automatic check_quiet(input string name, input logic exp_busy);
    n_vec++;
    if (o_ready !== 1'b0 || o_busy !== exp_busy || o_rd !== 32'h0 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s: ready=%b busy=%b rd=%h err=%b, required ready=0 busy=%b rd=0 err=0",
               name, o_ready, o_busy, o_rd, o_err, exp_busy);
    end
  endtask

  // Check a ready cycle against the front of the scoreboard.
  task automatic check_resp(input string name);
    exp_t e;
    n_vec++;
    if (o_ready !== 1'b1 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s: ready=%b busy=%b, required ready=1 busy=1", name, o_ready, o_busy);
    end else if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: ready with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      if (o_rd !== e.rd || o_err !== e.err) begin
        n_err++;
        $display("FAIL %s: rd=%h err=%b, required rd=%h err=%b", name, o_rd, o_err, e.rd, e.err);
      end
    end
  endtask

  // One access, started in an IDLE cycle at its negedge (cycle 0).
  // It returns at the negedge of the first IDLE cycle after ready.
  task automatic access(input int sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input string name);
    int l;
    l = lat_of(sel);
    cur = sel;
    req_drv = 1'b1; we = w; adr = a; wd = d; be = b;
    push_expect(sel, w, a, d, b);
    for (int k = 1; k <= l + 2; k++) begin
      @(negedge clk);
      if (k == l + 1) check_resp(name);
      else check_quiet(name, (k <= l + 1));
      if (k == 1) begin
        req_drv = 1'b0; we = 1'b0; adr = 32'h0; wd = 32'h0; be = 4'h0;
      end
    end
  endtask

  task automatic test_reset;
    cur = 0;
    @(negedge clk);
    check_quiet("reset_state", 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("after_reset", 1'b0);
    access(0, 1'b1, 32'h10, 32'h11111111, 4'hF, "rst_prefill");
    // Start the write that reset will abort.
    req_drv = 1'b1; we = 1'b1; adr = 32'h10; wd = 32'hDEADBEEF; be = 4'hF;
    @(negedge clk);
    req_drv = 1'b0;
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_busy_before: busy=%b, required 1", o_busy);
    end
    reset = 1'b1;
    #1;
    check_quiet("rst_async", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_quiet("rst_no_ready", 1'b0);
    end
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, "rst_prior_contents");
  endtask

  task automatic test_basic;
    access(0, 1'b1, 32'h08, 32'h12345678, 4'hF, "basic_write");
    access(0, 1'b0, 32'h08, 32'h0, 4'h0, "basic_read");
  endtask

  task automatic test_byte_enables;
    access(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, "be_write");
    access(0, 1'b0, 32'h08, 32'h0, 4'h0, "be_read");
    access(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000, "be_zero_write");
    access(0, 1'b0, 32'h09, 32'h0, 4'h0, "be_zero_read");
  endtask

  // Hold req through three full transactions.
  // Ready may pulse only once per LAT+2 cycles.
  task automatic test_held_req(input int sel);
    int p;
    int l;
    int n_ready;
    l = lat_of(sel);
    p = l + 2;
    n_ready = 0;
    cur = sel;
    req_drv = 1'b1; we = 1'b0; adr = 32'h08; wd = 32'h0; be = 4'h0;
    for (int i = 0; i < 3; i++) push_expect(sel, 1'b0, 32'h08, 32'h0, 4'h0);
    for (int k = 1; k <= 3 * p; k++) begin
      @(negedge clk);
      if (o_ready === 1'b1) n_ready++;
      if ((k % p) == l + 1) check_resp("held_ready");
      else check_quiet("held_quiet", ((k % p) != 0));
      if (k == 3 * p) req_drv = 1'b0;
    end
    n_vec++;
    if (n_ready != 3) begin
      n_err++;
      $display("FAIL held_count: readies=%0d, required 3", n_ready);
    end
    @(negedge clk);
    check_quiet("held_after", 1'b0);
  endtask

  task automatic test_zero_latency;
    access(1, 1'b1, 32'h08, 32'h0F1E2D3C, 4'hF, "lat0_write");
    access(1, 1'b0, 32'h08, 32'h0, 4'h0, "lat0_read");
    test_held_req(1);
  endtask

  task automatic test_range;
    access(0, 1'b1, 32'h00, 32'h0BADF00D, 4'hF, "range_prefill");
    access(0, 1'b1, 32'h100, 32'h55AA55AA, 4'hF, "range_write");
    access(0, 1'b0, 32'h00, 32'h0, 4'h0, "range_word0");
    access(0, 1'b0, 32'h104, 32'h0, 4'h0, "range_read");
  endtask

  task automatic test_back_to_back;
    access(0, 1'b1, 32'h00, 32'hCAFEF00D, 4'hF, "raw_write");
    access(0, 1'b0, 32'h00, 32'h0, 4'h0, "raw_read");
    access(1, 1'b1, 32'h00, 32'hCAFEF00D, 4'hF, "raw0_write");
    access(1, 1'b0, 32'h00, 32'h0, 4'h0, "raw0_read");
  endtask

  initial begin
    n_vec = 0; n_err = 0; cur = 0;
    reset = 1'b1; req_drv = 1'b0; we = 1'b0; adr = 32'h0; wd = 32'h0; be = 4'h0;
    test_reset;
    test_basic;
    test_byte_enables;
    test_held_req(0);
    test_zero_latency;
    test_range;
    test_back_to_back;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
